// File: rtl/draw_bar_array.sv
//==============================================================================
// Module      : draw_bar_array
// Description : A row of vertically scrolling rectangular bars for a
//               pixel-scanned display. Each bar has a fixed lane (x) and a
//               y register that advances by SPEED on every frame tick while
//               running, wrapping to the top at SCREEN_H and scoring each
//               wrap. Per-pixel hit outputs are registered (one clock of
//               latency).
//               Optional feature macro: BAR_COLLISION_EN
//                 adds iplayer_on / ocollision. A sticky collision flag
//                 holds the motion paused until the next start pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module draw_bar_array #(
    parameter int          NUM_BARS   = 4,
    parameter int          BAR_WIDTH  = 40,
    parameter int          BAR_HEIGHT = 50,
    parameter int          LANE_X0    = 120,
    parameter int          LANE_PITCH = 80,
    parameter int          Y_STAGGER  = 120,
    parameter int          SCREEN_H   = 480,
    parameter int          SPEED      = 2,
    parameter logic [9:0]  BAR_RGB    = 10'b0
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic [9:0]  ipixel_x,
    input  logic [9:0]  ipixel_y,
    input  logic        iframe_tick,
    input  logic        istart,
    input  logic        ipause,
`ifdef BAR_COLLISION_EN
    input  logic        iplayer_on,
    output logic        ocollision,
`endif
    output logic        obar_on,
    output logic [9:0]  obar_RGB,
    output logic [2:0]  obar_idx,
    output logic [7:0]  opassed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [9:0]            r_y [NUM_BARS];
    logic [7:0]            r_passed;

    logic [NUM_BARS-1:0]   w_wrap;
    logic [NUM_BARS-1:0]   w_hit;
    logic [9:0]            w_y_move [NUM_BARS];
    logic [3:0]            w_wrap_cnt;
    logic [8:0]            w_passed_sum;
    logic [7:0]            w_passed_next;
    logic                  w_move;
    logic                  w_any_hit;
    logic [2:0]            w_hit_idx;
    logic                  w_force_pause;

    // Starting y of a bar: staggered down the screen, folded into range.
    function automatic logic [9:0] init_y(input int idx);
        int v;
        v = (idx * Y_STAGGER) % SCREEN_H;
        return 10'(v);
    endfunction

    // Motion happens only while running; a start pulse takes priority.
    assign w_move = (r_state == RUN) && iframe_tick && !istart;

    // Per-bar next position, wrap detection and pixel hit test.
    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        localparam logic [11:0] XS = 12'(LANE_X0 + g * LANE_PITCH);
        localparam logic [11:0] XE = 12'(LANE_X0 + g * LANE_PITCH + BAR_WIDTH);

        logic [10:0] w_y_sum;
        logic [11:0] w_px;
        logic [11:0] w_py;
        logic [11:0] w_ys;

        // The sum is kept 11 bits wide so it cannot overflow before the
        // compare against the screen height.
        assign w_y_sum     = {1'b0, r_y[g]} + 11'(SPEED);
        assign w_wrap[g]   = (w_y_sum >= 11'(SCREEN_H));
        assign w_y_move[g] = w_wrap[g] ? 10'd0 : w_y_sum[9:0];

        // Strict inequalities: the outline pixels do not belong to the bar.
        assign w_px = {2'b00, ipixel_x};
        assign w_py = {2'b00, ipixel_y};
        assign w_ys = {2'b00, r_y[g]};
        assign w_hit[g] = (w_px > XS) && (w_px < XE) &&
                          (w_py > w_ys) && (w_py < (w_ys + 12'(BAR_HEIGHT)));
    end

    // Count the wraps occurring on this tick and saturate the score.
    always_comb begin
        w_wrap_cnt = 4'd0;
        for (int i = 0; i < NUM_BARS; i++) begin
            w_wrap_cnt = w_wrap_cnt + {3'b000, w_wrap[i]};
        end
        w_passed_sum  = {1'b0, r_passed} + {5'b00000, w_wrap_cnt};
        w_passed_next = w_passed_sum[8] ? 8'hFF : w_passed_sum[7:0];
    end

    // Lowest-index bar wins when several bars cover the same pixel.
    always_comb begin
        w_any_hit = 1'b0;
        w_hit_idx = 3'd0;
        for (int i = NUM_BARS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any_hit = 1'b1;
                w_hit_idx = 3'(i);
            end
        end
    end

`ifdef BAR_COLLISION_EN
    logic r_collision;
    logic w_collision_set;

    // A collision is the player pixel overlapping the registered bar pixel.
    assign w_collision_set = (r_state == RUN) && iplayer_on && obar_on;
    assign w_force_pause   = r_collision || w_collision_set;
    assign ocollision      = r_collision;

    // Sticky collision flag; only a reset or a new start clears it.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_collision <= 1'b0;
        end else if (istart) begin
            r_collision <= 1'b0;
        end else if (w_collision_set) begin
            r_collision <= 1'b1;
        end
    end
`else
    assign w_force_pause = 1'b0;
`endif

    // State register.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start restarts from any state, pause freezes RUN.
    always_comb begin
        w_state_next = r_state;
        if (istart) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                RUN:     if (ipause || w_force_pause) w_state_next = PAUSED;
                PAUSED:  if (!ipause && !w_force_pause) w_state_next = RUN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Bar positions and score: reload on reset/start, advance on a tick.
    always_ff @(posedge iclk) begin
        if (ireset || istart) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                r_y[i] <= init_y(i);
            end
            r_passed <= 8'd0;
        end else if (w_move) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                r_y[i] <= w_y_move[i];
            end
            r_passed <= w_passed_next;
        end
    end

    assign opassed = r_passed;

    // Registered pixel outputs, one clock behind the pixel coordinate.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            obar_on  <= 1'b0;
            obar_RGB <= 10'd0;
            obar_idx <= 3'd0;
        end else begin
            obar_on  <= w_any_hit;
            obar_RGB <= w_any_hit ? BAR_RGB : 10'd0;
            obar_idx <= w_hit_idx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_draw_bar_array.sv
//==============================================================================
// Module      : tb_draw_bar_array
// Description : Directed self-checking bench for draw_bar_array. Bar
//               positions are observed through the pixel hit outputs.
//               Define BAR_COLLISION_EN to exercise the collision feature.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_draw_bar_array;

    localparam logic [9:0] C_RGB = 10'h2A5;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] px, py;
    logic       tick, start, pause;
    logic       bar_on;
    logic [9:0] bar_rgb;
    logic [2:0] bar_idx;
    logic [7:0] passed;

    logic       tick2, start2;
    logic       bar_on2;
    logic [9:0] bar_rgb2;
    logic [2:0] bar_idx2;
    logic [7:0] passed2;

`ifdef BAR_COLLISION_EN
    logic       player_on;
    logic       collision;
    logic       collision2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    draw_bar_array #(
        .BAR_RGB (C_RGB)
    ) u_dut (
        .iclk        (clk),
        .ireset      (rst),
        .ipixel_x    (px),
        .ipixel_y    (py),
        .iframe_tick (tick),
        .istart      (start),
        .ipause      (pause),
`ifdef BAR_COLLISION_EN
        .iplayer_on  (player_on),
        .ocollision  (collision),
`endif
        .obar_on     (bar_on),
        .obar_RGB    (bar_rgb),
        .obar_idx    (bar_idx),
        .opassed     (passed)
    );

    // Eight bars, half starting at 0 and half at 240, SPEED 240: four wraps
    // on every tick, used for the multi-wrap count and score saturation.
    draw_bar_array #(
        .NUM_BARS  (8),
        .Y_STAGGER (240),
        .SPEED     (240)
    ) u_dut_sat (
        .iclk        (clk),
        .ireset      (rst),
        .ipixel_x    (px),
        .ipixel_y    (py),
        .iframe_tick (tick2),
        .istart      (start2),
        .ipause      (1'b0),
`ifdef BAR_COLLISION_EN
        .iplayer_on  (1'b0),
        .ocollision  (collision2),
`endif
        .obar_on     (bar_on2),
        .obar_RGB    (bar_rgb2),
        .obar_idx    (bar_idx2),
        .opassed     (passed2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a pixel, then check the registered result one clock later.
    task automatic probe(input string tag, input int x, input int y,
                         input logic exp_on, input int exp_idx);
        @(negedge clk);
        px = 10'(x);
        py = 10'(y);
        @(negedge clk);
        check({tag, ".on"},  {31'd0, bar_on}, {31'd0, exp_on});
        check({tag, ".idx"}, {29'd0, bar_idx}, 32'(exp_idx));
        check({tag, ".rgb"}, {22'd0, bar_rgb}, exp_on ? {22'd0, C_RGB} : 32'd0);
    endtask

    task automatic frame_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
    endtask

    task automatic frame_ticks2(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); tick2 = 1'b1;
            @(negedge clk); tick2 = 1'b0;
        end
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; px = 10'd0; py = 10'd0;
        tick = 1'b0; start = 1'b0; pause = 1'b0;
        tick2 = 1'b0; start2 = 1'b0;
`ifdef BAR_COLLISION_EN
        player_on = 1'b0;
`endif
        // Reset state
        px = 10'd140; py = 10'd20;   // a hit pixel: outputs must still be 0
        repeat (3) @(negedge clk);
        check("rst.on",     {31'd0, bar_on}, 32'd0);
        check("rst.rgb",    {22'd0, bar_rgb}, 32'd0);
        check("rst.idx",    {29'd0, bar_idx}, 32'd0);
        check("rst.passed", {24'd0, passed}, 32'd0);
        rst = 1'b0;

        // IDLE: ticks ignored, hit test live. y = 0,120,240,360.
        frame_ticks(3);
        probe("idle.in0",    140, 20,  1'b1, 0);
        probe("idle.xedge",  120, 20,  1'b0, 0);
        probe("idle.xend",   160, 20,  1'b0, 0);
        probe("idle.ytop",   140, 0,   1'b0, 0);
        probe("idle.ylast",  140, 49,  1'b1, 0);
        probe("idle.yend",   140, 50,  1'b0, 0);
        probe("idle.gap",    140, 170, 1'b0, 0);
        probe("idle.in1",    220, 121, 1'b1, 1);
        probe("idle.x1edge", 200, 121, 1'b0, 0);

        // Start, 10 ticks: y0=20, y1=140
        pulse_start();
        frame_ticks(10);
        probe("t10.y0in",  140, 21,  1'b1, 0);
        probe("t10.y0out", 140, 20,  1'b0, 0);
        probe("t10.y1in",  220, 141, 1'b1, 1);
        probe("t10.y1out", 220, 140, 1'b0, 0);
        check("t10.passed", {24'd0, passed}, 32'd0);

        // 59 ticks total: y3=478, no wrap yet
        frame_ticks(49);
        check("t59.passed", {24'd0, passed}, 32'd0);
        probe("t59.y3",  380, 479, 1'b1, 3);
        // Tick 60: y3 wraps to 0
        frame_ticks(1);
        check("t60.passed", {24'd0, passed}, 32'd1);
        probe("t60.y3in",  380, 1,   1'b1, 3);
        probe("t60.y3out", 380, 0,   1'b0, 0);
        probe("t60.y0",    140, 121, 1'b1, 0);

        // Pause across 5 ticks: y0 holds at 120
        @(negedge clk); pause = 1'b1;
        frame_ticks(5);
        probe("pause.in",  140, 121, 1'b1, 0);
        probe("pause.out", 140, 120, 1'b0, 0);
        check("pause.passed", {24'd0, passed}, 32'd1);
        @(negedge clk); pause = 1'b0;
        frame_ticks(1);
        probe("resume.in",  140, 123, 1'b1, 0);
        probe("resume.out", 140, 122, 1'b0, 0);

        // Start coincident with tick: reload, no move
        @(negedge clk); start = 1'b1; tick = 1'b1;
        @(negedge clk); start = 1'b0; tick = 1'b0;
        check("st_tick.passed", {24'd0, passed}, 32'd0);
        probe("st_tick.y0", 140, 1,   1'b1, 0);
        probe("st_tick.y3", 380, 361, 1'b1, 3);
        frame_ticks(1);
        probe("st_tick.run_in",  140, 3, 1'b1, 0);
        probe("st_tick.run_out", 140, 2, 1'b0, 0);

`ifdef BAR_COLLISION_EN
        check("coll.idle", {31'd0, collision}, 32'd0);
        // 69 more ticks: y0=140, pixel (140,170) lies in bar 0
        frame_ticks(69);
        @(negedge clk); px = 10'd140; py = 10'd170; player_on = 1'b1;
        repeat (2) @(negedge clk);
        player_on = 1'b0;
        check("coll.set", {31'd0, collision}, 32'd1);
        frame_ticks(3);
        check("coll.sticky", {31'd0, collision}, 32'd1);
        probe("coll.hold_in",  140, 141, 1'b1, 0);
        probe("coll.hold_out", 140, 140, 1'b0, 0);
        pulse_start();
        check("coll.clear", {31'd0, collision}, 32'd0);
        frame_ticks(1);
        probe("coll.run", 140, 3, 1'b1, 0);
`endif

        // Reset dominates start; afterwards IDLE ignores ticks
        frame_ticks(4);
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        frame_ticks(2);
        check("rst2.passed", {24'd0, passed}, 32'd0);
        probe("rst2.y0in",  140, 1, 1'b1, 0);
        probe("rst2.y1",    220, 121, 1'b1, 1);

        // Four simultaneous wraps per tick, score saturates at 255
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        frame_ticks2(1);
        check("sat.t1", {24'd0, passed2}, 32'd4);
        frame_ticks2(62);
        check("sat.t63", {24'd0, passed2}, 32'd252);
        frame_ticks2(1);
        check("sat.t64", {24'd0, passed2}, 32'd255);
        frame_ticks2(1);
        check("sat.t65", {24'd0, passed2}, 32'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
